// File: rtl/mips_inst_enc.sv
// Packs decoded MIPS instruction fields into 32-bit words, buffers them in a
// 2-entry FIFO and streams them into instruction memory. Macro: INST_ENC_STRICT_EN.
module mips_inst_enc #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opc,
  input  logic [5:0]        req_funct,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_pulse,
  output logic [15:0]       err_count,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

`ifdef INST_ENC_STRICT_EN
  function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] funct,
                                    input logic [4:0] rt);
    logic ok;
    case (opc)
      6'd0:       ok = funct inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd9,
                                     [6'd32:6'd39], 6'd42, 6'd43};
      6'd1:       ok = rt inside {5'd0, 5'd1, 5'd16, 5'd17};
      6'd2, 6'd3: ok = 1'b1;
      default:    ok = opc inside {[6'd4:6'd15], 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                                   6'h28, 6'h29, 6'h2b};
    endcase
    return ok;
  endfunction
`endif

  logic        legal;
  logic [31:0] word;
  logic [4:0]  rs_m, rt_m, rd_m, sh_m;

  always_comb begin
    rs_m = req_rs;
    rt_m = req_rt;
    rd_m = req_rd;
    sh_m = req_shamt;
    word = '0;
    case (req_opc)
      6'd0: begin
        case (req_funct)
          6'd0, 6'd2, 6'd3: rs_m = '0;
          6'd4, 6'd6, 6'd7: sh_m = '0;
          6'd8: begin
            rt_m = '0;
            rd_m = '0;
            sh_m = '0;
          end
          6'd9: begin
            rt_m = '0;
            sh_m = '0;
          end
          default: ;
        endcase
        word = {req_opc, rs_m, rt_m, rd_m, sh_m, req_funct};
      end
      6'd1:       word = {req_opc, rs_m, rt_m, req_imm};
      6'd2, 6'd3: word = {req_opc, req_target};
      default: begin
        if (req_opc == 6'h0F) rs_m = '0;
        if (req_opc == 6'd6 || req_opc == 6'd7) rt_m = '0;
        word = {req_opc, rs_m, rt_m, req_imm};
      end
    endcase
`ifdef INST_ENC_STRICT_EN
    legal = is_legal(req_opc, req_funct, req_rt);
`else
    legal = 1'b1;
`endif
  end

  logic [31:0] mem [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        accept, push, pop;

  assign req_ready = (count != 2'd2);
  assign wr_en     = (count != 2'd0);
  assign wr_data   = wr_en ? mem[head] : '0;
  assign tail      = head ^ count[0];
  assign accept    = req_valid && req_ready;
  assign push      = accept && legal && !flush;
  assign pop       = wr_en && wr_ready && !flush;

  always_ff @(posedge clock) begin
    if (push) mem[tail] <= word;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count         <= '0;
      head          <= 1'b0;
      wr_addr       <= BASE;
      words_written <= '0;
      err_pulse     <= 1'b0;
      err_count     <= '0;
    end else if (flush) begin
      count         <= '0;
      head          <= 1'b0;
      wr_addr       <= BASE;
      words_written <= '0;
      err_pulse     <= 1'b0;
    end else begin
      count     <= count + 2'(push) - 2'(pop);
      err_pulse <= accept && !legal;
      if (accept && !legal && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (pop) begin
        head    <= ~head;
        wr_addr <= wr_addr + 1'b1;
        if (words_written != '1) words_written <= words_written + 1'b1;
      end
    end
  end

endmodule

// File: doc/mips_inst_enc.md
# mips_inst_enc

Instruction encoder and program loader for the MIPS core's simulation and bring-up environment. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words. It buffers the words in a 2-entry FIFO and writes them sequentially into instruction memory through a write port with backpressure. It covers the same instruction set the core decodes; illegal requests are counted, not written.

## Interface

- ADDR_W, 10: instruction memory word-address width.
- BASE_ADDR, 0: first word address written after reset or flush.
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO and address counter.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_opc  in  6  primary opcode.
- req_funct  in  6  function field, used when opc=0.
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register and shift fields.
- req_imm  in  16  immediate or branch offset.
- req_target  in  26  jump target, used when opc=2/3.
- wr_en  out  1  memory write valid.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  encoded instruction.
- err_pulse  out  1  one-cycle flag: an illegal request was accepted.
- err_count  out  16  saturating illegal-request count.
- words_written  out  ADDR_W+1  writes completed since reset or flush.

## Operation

- Formats:
  - R (opc 0): {opc,rs,rt,rd,shamt,funct}.
  - REGIMM (opc 1): {opc,rs,rt,imm}.
  - J (opc 2,3): {opc,target}.
  - I (all others): {opc,rs,rt,imm}.
- Legal R funct: 0,2,3,4,6,7,8,9,32–39,42,43.
- Legal REGIMM rt: 0,1,16,17.
- Legal I opc: 4–15, 0x20,0x21,0x23,0x24,0x25,0x28,0x29,0x2b.
- Masking, with unused fields forced to zero:
  - sll/srl/sra: rs=0.
  - sllv/srlv/srav: shamt=0.
  - jr: rt=rd=shamt=0.
  - jalr: rt=shamt=0.
  - lui: rs=0.
  - blez/bgtz: rt=0.
- Accept when req_valid && req_ready.
  - Legal: the packed word is pushed into the FIFO.
  - Illegal: nothing is pushed, err_pulse is raised, err_count increments (saturating at 0xFFFF).
- FIFO is 2 entries, in order.
  - wr_en = FIFO non-empty.
  - wr_data = head word; wr_addr = address counter.
- Write completes on wr_en && wr_ready: pop head, address counter +1 (wraps mod 2^ADDR_W), words_written +1 (saturating).
- flush clears the FIFO, reloads BASE_ADDR and zeroes words_written. err_count is kept. Flush wins over a simultaneous accept or write; that request is dropped.

## Timing

- Reset values:
  - req_ready=1; wr_en=0; wr_data=0.
  - wr_addr=BASE_ADDR; err_pulse=0; err_count=0; words_written=0.
- Latency: a request accepted at edge N gives wr_en=1 with its word from edge N onward, i.e. in cycle N+1.
- req_ready = (FIFO count < 2), registered, with no combinational path from wr_ready. At count 2 ready stays low even if a pop occurs the same cycle.
- Push and pop at count 1: count stays 1 and the head advances.
- While wr_en && !wr_ready, wr_addr and wr_data hold stable.
- err_pulse is high for exactly the cycle after the edge that accepted an illegal request.
- Reset asserted mid-drain: all outputs go to reset values immediately and buffered words are lost.

## Configuration

- INST_ENC_STRICT_EN defined: the legality checks above apply.
- INST_ENC_STRICT_EN undefined:
  - Every request is legal; err_pulse and err_count stay 0.
  - Unknown opc ≥ 2 is packed as I-format.
  - Unknown R funct or REGIMM rt is packed raw without masking.

## Test plan

- addu: opc 0, funct 33, rs 1, rt 2, rd 3 -> wr_data 0x00221821 at wr_addr BASE_ADDR in cycle N+1; words_written 1.
- sll: funct 0, rs 7, rt 3, rd 2, shamt 4 -> 0x00031100 (rs masked). lui: opc 0x0F, rs 9, rt 5, imm 0x1234 -> 0x3C051234.
- j: opc 2, target 0x100 -> 0x08000100. Then beq 1,2,0xFFFF -> 0x1022FFFF at the next address.
- Backpressure: wr_ready=0 for 5 cycles while 3 requests are offered. Required response:
  - req_ready drops after two accepts.
  - wr_data holds the first word.
  - On release, the words drain in order at BASE_ADDR, +1, +2.
- Strict build, opc 0x3F: handshake completes, no write, err_pulse for one cycle, err_count=1, wr_addr unchanged. Non-strict build: word 0xFC000000|fields is written.
- ADDR_W=2, 5 writes -> wr_addr sequence 0,1,2,3,0. Then:
  - flush while 1 word is buffered -> wr_en=0 and wr_addr=BASE_ADDR.
  - reset_n low mid-drain -> all outputs at reset values.
